// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: word-side bundle of uart_rx_core (received word, status flags and
// the valid/ready handshake). The receiver drives it through the master modport and the
// consuming logic (FIFO, command parser) attaches through the slave modport.
`timescale 1ns/1ps
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output data, valid, frame_err, parity_err, overrun, busy,
    input  ready
  );

  modport slave (
    input  data, valid, frame_err, parity_err, overrun, busy,
    output ready
  );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: parametrised UART receiver (5..9 data bits, none/odd/even parity, 1 or 2
// stop bits) with false-start rejection, valid/ready output and per-word framing, parity
// and overrun status.
// Optional feature macro: UART_RX_MAJORITY_EN -- when defined, every sample point is the
// 2-of-3 vote of rx_s around the nominal point; frame timing is unchanged.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  uart_rx_core_if.master    word_if
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] FULL_LIM  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LIM  = CNT_W'(HALF_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [1:0]       PAR_MODE  = 2'(PARITY);
  localparam logic             PAR_EN    = (PAR_MODE != 2'd0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Expected parity bit: even mode sends the XOR of the data, odd mode its inverse.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] word, input logic [1:0] mode);
    logic x;
    x = ^word;
    if (mode == 2'd1) begin
      return ~x;
    end else begin
      return x;
    end
  endfunction

`ifdef UART_RX_MAJORITY_EN
  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  // Synchroniser and line sampling
  logic rx_meta_q;
  logic rx_s_q;

  // FSM and datapath state
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;

  // Output registers
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;

  logic [CNT_W-1:0]     limit_s;
  logic                 at_lim_s;
  logic                 sample_now_s;
  logic                 sample_bit_s;
  logic                 commit_s;
  logic                 hs_s;

  // Two-flop synchroniser for the asynchronous rx line; idles high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Baud counter limit: half a bit while centring on the start bit, a full bit otherwise.
  always_comb begin
    limit_s = FULL_LIM;
    case (state_q)
      S_START: limit_s = HALF_LIM;
      default: limit_s = FULL_LIM;
    endcase
    at_lim_s = (cnt_q == limit_s);
  end

`ifdef UART_RX_MAJORITY_EN
  logic vote_a_q;
  logic vote_b_q;
  logic pend_q;

  // Collect votes at limit-1 and limit; the decision (with the third vote) lands one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_a_q <= 1'b1;
      vote_b_q <= 1'b1;
      pend_q   <= 1'b0;
    end else begin
      if (cnt_q == (limit_s - CNT_ONE)) begin
        vote_a_q <= rx_s_q;
      end
      if (at_lim_s) begin
        vote_b_q <= rx_s_q;
      end
      pend_q <= at_lim_s && (state_q != S_IDLE);
    end
  end

  // Decision point is the cycle after the nominal sample point.
  always_comb begin
    sample_now_s = pend_q;
    sample_bit_s = maj3(vote_a_q, vote_b_q, rx_s_q);
  end
`else
  // Single sample of the synchronised line at the counter limit.
  always_comb begin
    sample_now_s = at_lim_s;
    sample_bit_s = rx_s_q;
  end
`endif

  // Receive FSM next state, baud/bit counters, shift register and internal error flags.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    ferr_d   = ferr_q;
    perr_d   = perr_q;
    commit_s = 1'b0;
    if (at_lim_s) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        bit_d = 4'd0;
        if (!rx_s_q) begin
          state_d = S_START;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (sample_now_s) begin
          bit_d = 4'd0;
          if (sample_bit_s) begin
            // Line back high at mid start bit: glitch, not a frame.
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (sample_now_s) begin
          shift_d = {sample_bit_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_d   = 4'd0;
            state_d = PAR_EN ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PAR: begin
        if (sample_now_s) begin
          perr_d  = sample_bit_s ^ parity_of(shift_q, PAR_MODE);
          state_d = S_STOP;
        end else begin
          state_d = S_PAR;
        end
      end
      S_STOP: begin
        if (sample_now_s) begin
          ferr_d = ferr_q | ~sample_bit_s;
          if (bit_q == LAST_STOP) begin
            // Commit now so a start edge in the rest of the stop bit is caught.
            commit_s = 1'b1;
            state_d  = S_IDLE;
            bit_d    = 4'd0;
            cnt_d    = CNT_ZERO;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
        bit_d   = 4'd0;
      end
    endcase
  end

  // Output word, status and handshake; a commit always wins over a same-cycle handshake.
  always_comb begin
    hs_s    = valid_q & word_if.ready;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    ovr_d   = ovr_q;
    busy_d  = (state_d != S_IDLE);
    if (commit_s) begin
      data_d  = shift_q;
      fe_d    = ferr_d;
      pe_d    = perr_q;
      valid_d = 1'b1;
      if (valid_q && !word_if.ready) begin
        ovr_d = 1'b1;
      end else begin
        ovr_d = ovr_q;
      end
    end else if (hs_s) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      valid_d = valid_q;
      ovr_d   = ovr_q;
    end
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      bit_q   <= 4'd0;
      shift_q <= {DATA_BITS{1'b0}};
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= {DATA_BITS{1'b0}};
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign word_if.data       = data_q;
  assign word_if.valid      = valid_q;
  assign word_if.frame_err  = fe_q;
  assign word_if.parity_err = pe_q;
  assign word_if.overrun    = ovr_q;
  assign word_if.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed bench for uart_rx_core. dut1 is the default 8N1 build, dut2
// uses even parity with two stop bits. Bit time 8681 ns on a 50 MHz clock.
`timescale 1ns/1ps
module tb_uart_rx_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx1 = 1'b1;
  logic rx2 = 1'b1;

  uart_rx_core_if #(.DATA_BITS(8)) if1 ();
  uart_rx_core_if #(.DATA_BITS(8)) if2 ();

  uart_rx_core #(.CLK_FREQ(50000000), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut1 (.clk(clk), .rst(rst), .rx_i(rx1), .word_if(if1));

  uart_rx_core #(.CLK_FREQ(50000000), .BAUD(115200), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2))
    dut2 (.clk(clk), .rst(rst), .rx_i(rx2), .word_if(if2));

  always #10 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Observation of the word side, sampled on the falling edge.
  logic [7:0] cap1_data = 8'h00;
  logic       cap1_fe   = 1'b0;
  logic       cap1_pe   = 1'b0;
  logic       cap1_ovr  = 1'b0;
  int         vcnt1     = 0;
  int         bcnt1     = 0;
  logic       bprev1    = 1'b0;
  time        fall_t1   = 0;
  logic [7:0] cap2_data = 8'h00;
  logic       cap2_fe   = 1'b0;
  logic       cap2_pe   = 1'b0;
  int         vcnt2     = 0;

  // Capture each delivered word and track busy on both receivers.
  always @(negedge clk) begin
    if (if1.valid) begin
      cap1_data <= if1.data;
      cap1_fe   <= if1.frame_err;
      cap1_pe   <= if1.parity_err;
      cap1_ovr  <= if1.overrun;
      vcnt1     <= vcnt1 + 1;
    end
    if (if1.busy) bcnt1 <= bcnt1 + 1;
    if (bprev1 && !if1.busy) fall_t1 <= $time;
    bprev1 <= if1.busy;
    if (if2.valid) begin
      cap2_data <= if2.data;
      cap2_fe   <= if2.frame_err;
      cap2_pe   <= if2.parity_err;
      vcnt2     <= vcnt2 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive n line bits, LSB first, one bit time each.
  task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 1) rx1 = bits[i];
      else          rx2 = bits[i];
      #8681;
    end
  endtask

  int  v0, v2, b0;
  time t0;
  longint dt;

  initial begin
    if1.ready = 1'b1;
    if2.ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_data",   {24'd0, if1.data}, 32'h0);
    chk("rst_valid",  {31'd0, if1.valid}, 32'h0);
    chk("rst_fe",     {31'd0, if1.frame_err}, 32'h0);
    chk("rst_pe",     {31'd0, if1.parity_err}, 32'h0);
    chk("rst_ovr",    {31'd0, if1.overrun}, 32'h0);
    chk("rst_busy",   {31'd0, if1.busy}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0x48 with ready high
    v0 = vcnt1;
    t0 = $time;
    send_bits(1, {6'd0, 1'b1, 8'h48, 1'b0}, 10);
    #8681;
    chk("t1_vpulses", vcnt1 - v0, 32'd1);
    chk("t1_data",    {24'd0, cap1_data}, 32'h48);
    chk("t1_fe",      {31'd0, cap1_fe}, 32'h0);
    chk("t1_pe",      {31'd0, cap1_pe}, 32'h0);
    chk("t1_ovr",     {31'd0, cap1_ovr}, 32'h0);
    chk("t1_valid_after", {31'd0, if1.valid}, 32'h0);
    dt = longint'(fall_t1 - t0);
    chk("t1_busy_mid_stop", {31'd0, (dt > 64'sd80300) && (dt < 64'sd84640)}, 32'h1);

    // Even parity, two stop bits: 0x6C has even weight, so parity bit 0 is correct
    v2 = vcnt2;
    send_bits(2, {4'd0, 2'b11, 1'b0, 8'h6C, 1'b0}, 12);
    #8681;
    chk("t2a_vpulses", vcnt2 - v2, 32'd1);
    chk("t2a_data",    {24'd0, cap2_data}, 32'h6C);
    chk("t2a_pe",      {31'd0, cap2_pe}, 32'h0);
    chk("t2a_fe",      {31'd0, cap2_fe}, 32'h0);
    v2 = vcnt2;
    send_bits(2, {4'd0, 2'b11, 1'b1, 8'h6C, 1'b0}, 12);
    #8681;
    chk("t2b_vpulses", vcnt2 - v2, 32'd1);
    chk("t2b_data",    {24'd0, cap2_data}, 32'h6C);
    chk("t2b_pe",      {31'd0, cap2_pe}, 32'h1);
    chk("t2b_fe",      {31'd0, cap2_fe}, 32'h0);

    // 0x21 with the stop bit low (held low past mid-bit, then released)
    v0 = vcnt1;
    send_bits(1, {7'd0, 8'h21, 1'b0}, 9);
    rx1 = 1'b0;
    #5200;
    rx1 = 1'b1;
    #17362;
    chk("t3_vpulses", vcnt1 - v0, 32'd1);
    chk("t3_data",    {24'd0, cap1_data}, 32'h21);
    chk("t3_fe",      {31'd0, cap1_fe}, 32'h1);
    chk("t3_pe",      {31'd0, cap1_pe}, 32'h0);
    chk("t3_busy_after", {31'd0, if1.busy}, 32'h0);

    // 2000 ns glitch in IDLE: rejected as a false start
    v0 = vcnt1;
    b0 = bcnt1;
    rx1 = 1'b0;
    #2000;
    rx1 = 1'b1;
    repeat (300) @(negedge clk);
    chk("t4_no_word", vcnt1 - v0, 32'd0);
    chk("t4_busy_len_ok", {31'd0, ((bcnt1 - b0) >= 216) && ((bcnt1 - b0) <= 220)}, 32'h1);
    chk("t4_busy_after", {31'd0, if1.busy}, 32'h0);
    chk("t4_valid",      {31'd0, if1.valid}, 32'h0);

    // ready low, "He" back to back -> overrun
    @(negedge clk);
    if1.ready = 1'b0;
    send_bits(1, {6'd0, 1'b1, 8'h48, 1'b0}, 10);
    send_bits(1, {6'd0, 1'b1, 8'h65, 1'b0}, 10);
    #8681;
    @(negedge clk);
    chk("t5_valid", {31'd0, if1.valid}, 32'h1);
    chk("t5_data",  {24'd0, if1.data}, 32'h65);
    chk("t5_ovr",   {31'd0, if1.overrun}, 32'h1);
    if1.ready = 1'b1;
    @(negedge clk);
    if1.ready = 1'b0;
    chk("t5_hs_valid", {31'd0, if1.valid}, 32'h0);
    chk("t5_hs_ovr",   {31'd0, if1.overrun}, 32'h0);
    chk("t5_hs_data_hold", {24'd0, if1.data}, 32'h65);
    if1.ready = 1'b1;

    // Reset in the middle of the data bits of 0x6F
    send_bits(1, {7'd0, 8'h6F, 1'b0}, 5);
    #4000;
    chk("t6_busy_pre", {31'd0, if1.busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_data",  {24'd0, if1.data}, 32'h0);
    chk("t6_rst_valid", {31'd0, if1.valid}, 32'h0);
    chk("t6_rst_busy",  {31'd0, if1.busy}, 32'h0);
    chk("t6_rst_fe",    {31'd0, if1.frame_err}, 32'h0);
    chk("t6_rst_ovr",   {31'd0, if1.overrun}, 32'h0);
    rx1 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #8681;
    v0 = vcnt1;
    send_bits(1, {6'd0, 1'b1, 8'h57, 1'b0}, 10);
    #8681;
    chk("t6_vpulses", vcnt1 - v0, 32'd1);
    chk("t6_data",    {24'd0, cap1_data}, 32'h57);
    chk("t6_fe",      {31'd0, cap1_fe}, 32'h0);
    chk("t6_pe",      {31'd0, cap1_pe}, 32'h0);
    chk("t6_ovr",     {31'd0, cap1_ovr}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports configurable clock and baud rate, data width, parity mode and stop-bit count. Adds false-start rejection, a valid/ready output handshake, and per-word framing, parity and overrun status. Sits between the pad-side rx line and the byte-consuming logic (FIFO or command parser).

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 434 at defaults), HALF_BIT = CLKS_PER_BIT/2 (217)
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, asynchronous to clk, idles high
data  output  DATA_BITS  received word, LSB = first bit on the line
valid  output  1  data and status flags hold a word
ready  input  1  consumer accepts the word when valid && ready at a rising clk edge
frame_err  output  1  at least one stop bit sampled low (qualified by valid)
parity_err  output  1  parity mismatch; always 0 when PARITY = 0 (qualified by valid)
overrun  output  1  a word was overwritten before it was accepted (sticky)
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - data = 0, valid = 0, frame_err = 0, parity_err = 0, overrun = 0, busy = 0.
  - FSM = IDLE; both synchroniser flops = 1; bit counter and baud counter = 0.
- rx passes through a 2-flop synchroniser (rx_s), giving 2 cycles of latency. All sampling uses rx_s.
- Baud counter counts 0..limit. A sample point is the cycle where the counter equals its limit; the counter then clears.
- FSM states:
  - IDLE: rx_s == 0 -> START, counter cleared.
  - START: limit = HALF_BIT-1. At the sample point:
    - rx_s == 1 -> IDLE (false start; no flags, no output).
    - rx_s == 0 -> DATA, bit index = 0.
  - DATA: limit = CLKS_PER_BIT-1. Each sample shifts rx_s in, LSB first. After DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
  - PARITY: one sample at limit CLKS_PER_BIT-1. Expected bit:
    - even mode: XOR of the data bits.
    - odd mode: inverted XOR of the data bits.
    - Mismatch sets the internal perr.
  - STOP: STOP_BITS samples at limit CLKS_PER_BIT-1. Any low sample sets the internal ferr. On the last stop sample, commit the word and go to IDLE in the same cycle, so a start edge in the second half of the stop bit is detected.
- Commit, on the edge following the last stop sample:
  - data <= shift register; frame_err <= ferr; parity_err <= perr; valid <= 1.
  - If valid was already 1 and no handshake occurs in that cycle, overrun <= 1 and the old word is lost.
  - If commit and handshake coincide, the new word wins: valid stays 1 and overrun is unchanged.
- Handshake: valid && ready with no commit in that cycle -> valid <= 0 and overrun <= 0. data and the error flags hold their last values.
- Words with frame_err or parity_err are still delivered; the consumer decides what to do with them.
- busy = (state != IDLE), registered with the state.
- The bit counter is sized for 9 data bits and the baud counter for CLKS_PER_BIT; there is no wrap-around inside a frame.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: each sample point takes the 2-of-3 majority of rx_s at counter values limit-1, limit and limit+1. The state transition moves one cycle later, and the total frame timing is unchanged. The START check uses the same vote.
- Undefined: single sample of rx_s at the sample point, as described above.

Test Plan:
- 50 MHz clock, 8N1, rx frame 0x48 at 8681 ns per bit, ready = 1 -> valid pulses for 1 cycle with data = 0x48; frame_err, parity_err and overrun all 0; busy drops in the middle of the stop bit.
- Parameters PARITY = 2, STOP_BITS = 2. Send 0x6C with parity bit 0 -> parity_err = 0. Send 0x6C with parity bit 1 -> data = 0x6C, parity_err = 1.
- 8N1 frame 0x21 with the stop bit driven low -> data = 0x21, frame_err = 1, valid = 1.
- rx low pulse of 2000 ns (less than a half bit) while in IDLE -> FSM returns to IDLE, valid stays 0, busy high for about 217+2 cycles.
- ready = 0, send "He" (0x48, 0x65) back to back -> valid stays 1, data = 0x65, overrun = 1. Then assert ready for 1 cycle -> valid = 0, overrun = 0.
- Assert rst in the middle of the data bits of 0x6F -> all outputs are 0 immediately. Deassert rst and send 0x57 -> data = 0x57 with no flags.
